// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and small helpers for the ALU pipeline.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NEG = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_RL  = 3'b110;
  localparam logic [2:0] OP_RR  = 3'b111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Signed overflow of x + y given the sign bits of both addends and of the sum.
  function automatic logic add_ovf(input logic sx, input logic sy, input logic sr);
    return (sx == sy) && (sr != sx);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Valid/ready operand and result channels of the ALU pipeline.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_comb.sv
// Purely combinational ALU: result and {N, Z, C, V} for one operand pair.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter bit          ROT_BY_B = 1'b0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       sel_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o
);

  localparam int unsigned      AW     = $clog2(WIDTH);
  localparam int unsigned      MSB    = WIDTH - 1;
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] neg;
  logic [WIDTH-1:0] rol;
  logic [WIDTH-1:0] ror;
  logic [AW-1:0]    amt_raw;
  logic [AW-1:0]    amt;
  logic             rot_nz;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = a_i - b_i;
  assign neg  = '0 - a_i;

  assign amt_raw = ROT_BY_B ? b_i[AW-1:0] : AW'(1);
  // Non-power-of-two widths: fold amounts >= WIDTH back into range.
  assign amt     = ({1'b0, amt_raw} >= (AW + 1)'(WIDTH)) ? amt_raw - AW'(WIDTH) : amt_raw;
  assign rot_nz  = (amt_raw != '0);
  assign rol     = WIDTH'(({a_i, a_i} << amt) >> WIDTH);
  assign ror     = WIDTH'({a_i, a_i} >> amt);

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (sel_i)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = add_ovf(a_i[MSB], b_i[MSB], sum[MSB]);
      end
      OP_SUB: begin
        res   = diff;
        carry = (a_i < b_i);
        ovf   = add_ovf(a_i[MSB], ~b_i[MSB], diff[MSB]);
      end
      OP_AND: res = a_i & b_i;
      OP_NEG: begin
        res   = neg;
        carry = (a_i == '0);
        ovf   = (a_i == MinNeg);
      end
      OP_OR:  res = a_i | b_i;
      OP_XOR: res = a_i ^ b_i;
      OP_RL: begin
        res   = rol;
        carry = rot_nz & rol[0];
      end
      OP_RR: begin
        res   = ror;
        carry = rot_nz & ror[MSB];
      end
      default: ;
    endcase
  end

  always_comb begin
    result_o         = res;
    flags_o          = '0;
    flags_o[FLAG_N]  = res[MSB];
    flags_o[FLAG_Z]  = (res == '0);
    flags_o[FLAG_C]  = carry;
    flags_o[FLAG_V]  = ovf;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands, S2 holds result and flags.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter bit          ROT_BY_B = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_pipe_if.slave  alu_io
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       sel_q, sel_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       flags_q, flags_d;

  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;

  alu_comb #(
    .WIDTH    (WIDTH),
    .ROT_BY_B (ROT_BY_B)
  ) u_alu_comb (
    .a_i      (a_q),
    .b_i      (b_q),
    .sel_i    (sel_q),
    .result_o (alu_res),
    .flags_o  (alu_flags)
  );

  // Each stage refills in the same cycle its downstream drains, so no bubbles.
  assign s2_load = !out_valid_q || alu_io.out_ready;
  assign s1_load = !s1_valid_q || s2_load;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    flags_d     = flags_q;

    if (s1_load) begin
      s1_valid_d = alu_io.in_valid;
      if (alu_io.in_valid) begin
        a_d   = alu_io.a;
        b_d   = alu_io.b;
        sel_d = alu_io.sel;
      end
    end

    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d   = alu_res;
        flags_d = alu_flags;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= OP_ADD;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
    end
  end

  assign alu_io.in_ready  = !rst_i && s1_load;
  assign alu_io.out_valid = out_valid_q;
  assign alu_io.result    = out_q;
  assign alu_io.flags     = flags_q;

endmodule
